rs_dsp_seq_divider: RTL and testbench
=====================================

RS_DSP_SEQ_DIVIDER -- requirements
Module: rs_dsp_seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH_A, default 20, dividend and quotient width.
REQ-002 The block SHALL have parameter WIDTH_B, default 18, divisor and remainder width.
REQ-003 Ports SHALL be, in order:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-004 Operand ports SHALL be:
- a  input  WIDTH_A  dividend.
- b  input  WIDTH_B  divisor.
- unsigned_a  input  1  1 = a unsigned, 0 = a two's complement.
- unsigned_b  input  1  1 = b unsigned, 0 = b two's complement.
- start  input  1  request; sampled only in IDLE.
REQ-005 Result and status ports SHALL be:
- quotient  output  WIDTH_A  result.
- remainder  output  WIDTH_B  result.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse, result valid.
- div_zero  output  1  last completed operation had b == 0.

Function
REQ-006 States SHALL be IDLE, CALC, FIXUP and DONE.
REQ-007 In IDLE with start=1, the block SHALL latch a, b, unsigned_a and unsigned_b, and compute operand magnitudes.
REQ-008 From that IDLE cycle, if the latched b is nonzero the block SHALL enter CALC; otherwise it SHALL enter DONE directly.
REQ-009 CALC SHALL run exactly WIDTH_A cycles of restoring shift-subtract on magnitudes, then go to FIXUP.
REQ-010 FIXUP SHALL apply signs and register quotient, remainder and div_zero=0, then go to DONE.
REQ-011 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-012 Latency for nonzero b, counting the start-sampling edge as 0: done SHALL be high in cycle WIDTH_A+2 (22 at defaults).
REQ-013 For b == 0, done SHALL be high in cycle 1 with quotient all ones, remainder 0 and div_zero=1.
REQ-014 Operand sign SHALL be MSB AND NOT unsigned_x; quotient negative iff the operand signs differ.
REQ-015 Division SHALL truncate toward zero; a nonzero remainder SHALL take the dividend's sign.
REQ-016 Results SHALL be WIDTH_A/WIDTH_B two's-complement bit patterns.
REQ-017 Signed most-negative a divided by signed -1 SHALL give quotient 2^(WIDTH_A-1) as a bit pattern (0x80000) and remainder 0, with no flag.
REQ-018 start while busy=1 SHALL be ignored and not queued; the in-flight operation SHALL be unaffected.
REQ-019 start high in the same cycle as done SHALL be ignored; a new start is accepted only in the following IDLE cycle.
REQ-020 Operand inputs changing after acceptance SHALL not affect the in-flight result.
REQ-021 quotient, remainder and div_zero SHALL hold their values from the DONE cycle onward until the next DONE.

Reset
REQ-022 rst_n low SHALL immediately force state IDLE and set busy, done, quotient, remainder and div_zero to 0, including mid-operation.
REQ-023 An operation aborted by reset SHALL never produce done.
REQ-024 The first start after rst_n deasserts SHALL be accepted normally.

Configuration
REQ-025 The macro RS_DIV_SIGNED_EN SHALL select signed support.
REQ-026 With RS_DIV_SIGNED_EN defined, unsigned_a and unsigned_b SHALL be honoured per REQ-014 to REQ-017.
REQ-027 Without RS_DIV_SIGNED_EN, both operands SHALL always be treated as unsigned, unsigned_a and unsigned_b SHALL be ignored, and FIXUP SHALL still take one cycle so latency is unchanged.

Verification
REQ-028 a=100, b=7, both unsigned -> quotient=14, remainder=2, div_zero=0, done pulse in cycle 22 only, busy high in cycles 1-22.
REQ-029 With the macro: a=0xFFF9C (-100), b=7, unsigned_a=0, unsigned_b=1 -> quotient=0xFFFF2 (-14), remainder=0x3FFFE (-2).
REQ-030 Without the macro, same stimulus -> quotient=149782 (0x24916), remainder=2.
REQ-031 a=0x12345, b=0 -> done in cycle 1, quotient=0xFFFFF, remainder=0, div_zero=1.
REQ-032 With the macro: a=0x80000, b=0x3FFFF, both signed -> quotient=0x80000, remainder=0.
REQ-033 Busy and reset cases:
- start pulsed with new operands at cycle 5 -> original result returned at cycle 22, no second done.
- rst_n low at cycle 10 -> outputs 0 at once, no done; next operation after release correct.

Source files
------------

// File: rtl/rs_dsp_seq_divider.sv
// rs_dsp_seq_divider: sequential restoring divider, WIDTH_A-bit dividend by
// WIDTH_B-bit divisor. One quotient bit per cycle on operand magnitudes,
// followed by a one-cycle sign fixup and a one-cycle done pulse.
// A zero divisor skips the iteration entirely and reports div_zero.
// Optional feature macro: RS_DIV_SIGNED_EN -- when defined, unsigned_a and
// unsigned_b select two's-complement operands. Otherwise both operands are
// always unsigned.
module rs_dsp_seq_divider #(
    parameter int WIDTH_A = 20,
    parameter int WIDTH_B = 18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH_A-1:0] a,
    input  logic [WIDTH_B-1:0] b,
    input  logic               unsigned_a,
    input  logic               unsigned_b,
    input  logic               start,
    output logic [WIDTH_A-1:0] quotient,
    output logic [WIDTH_B-1:0] remainder,
    output logic               busy,
    output logic               done,
    output logic               div_zero
);

    localparam int CNT_W = $clog2(WIDTH_A + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH_A - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // iteration state
    logic [WIDTH_A-1:0] q_acc;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH_B-1:0] r_acc;      // partial remainder, always < divisor magnitude
    logic [WIDTH_B-1:0] mag_b_q;
    logic               neg_q;
    logic               neg_r;
    logic [CNT_W-1:0]   cnt;

    // operand sign/magnitude, evaluated from the live inputs in IDLE
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH_A-1:0] mag_a;
    logic [WIDTH_B-1:0] mag_b;

`ifdef RS_DIV_SIGNED_EN
    assign sign_a = a[WIDTH_A-1] & ~unsigned_a;
    assign sign_b = b[WIDTH_B-1] & ~unsigned_b;
`else
    logic unused_sign_ctrl;
    assign unused_sign_ctrl = unsigned_a ^ unsigned_b;
    assign sign_a = 1'b0;
    assign sign_b = 1'b0;
`endif

    // most-negative operands map to 2^(W-1), which still fits unsigned in W bits
    assign mag_a = sign_a ? -a : a;
    assign mag_b = sign_b ? -b : b;

    // one restoring step: shift in next dividend bit, subtract if it fits
    logic [WIDTH_B:0]   r_shift;
    logic [WIDTH_B-1:0] r_diff;
    logic               r_ge;

    assign r_shift = {r_acc, q_acc[WIDTH_A-1]};
    assign r_ge    = (r_shift >= {1'b0, mag_b_q});
    assign r_diff  = r_shift[WIDTH_B-1:0] - mag_b_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (b != '0) ? CALC : DONE;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // datapath: operand capture, iteration, sign fixup and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_acc     <= '0;
            r_acc     <= '0;
            mag_b_q   <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_acc   <= mag_a;
                        r_acc   <= '0;
                        mag_b_q <= mag_b;
                        neg_q   <= sign_a ^ sign_b;
                        neg_r   <= sign_a;
                        cnt     <= '0;
                        if (b == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_acc <= {q_acc[WIDTH_A-2:0], r_ge};
                    r_acc <= r_ge ? r_diff : r_shift[WIDTH_B-1:0];
                    cnt   <= cnt + CNT_ONE;
                end
                FIXUP: begin
                    quotient  <= neg_q ? -q_acc : q_acc;
                    remainder <= neg_r ? -r_acc : r_acc;
                    div_zero  <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_dsp_seq_divider.sv
// tb_rs_dsp_seq_divider: self-checking bench for rs_dsp_seq_divider at default
// widths. Expected results come from plain integer division in a reference
// function; signed expectations apply when RS_DIV_SIGNED_EN is defined.
module tb_rs_dsp_seq_divider;

    localparam int WA = 20;
    localparam int WB = 18;
    localparam int RUN_CYCLES = 30;

`ifdef RS_DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [WA-1:0] a;
    logic [WB-1:0] b;
    logic          unsigned_a;
    logic          unsigned_b;
    logic          start;
    logic [WA-1:0] quotient;
    logic [WB-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_zero;

    int total;
    int bad;

    rs_dsp_seq_divider #(
        .WIDTH_A(WA),
        .WIDTH_B(WB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .unsigned_a(unsigned_a),
        .unsigned_b(unsigned_b),
        .start     (start),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference: truncating integer division on the interpreted operand values
    function automatic void model(input logic [WA-1:0] ia, input logic [WB-1:0] ib,
                                  input logic iua, input logic iub,
                                  output logic [WA-1:0] q, output logic [WB-1:0] r,
                                  output logic dz);
        longint va, vb, vq, vr;
        va = longint'(ia);
        vb = longint'(ib);
        if (SIGNED_EN && !iua && ia[WA-1]) va = va - (longint'(1) << WA);
        if (SIGNED_EN && !iub && ib[WB-1]) vb = vb - (longint'(1) << WB);
        if (vb == 0) begin
            q  = '1;
            r  = '0;
            dz = 1'b1;
        end else begin
            vq = va / vb;
            vr = va % vb;
            q  = vq[WA-1:0];
            r  = vr[WB-1:0];
            dz = 1'b0;
        end
    endfunction

    // drive one operation and observe it for RUN_CYCLES cycles;
    // cycle 1 is the cycle after the start-sampling edge
    task automatic do_op(input logic [WA-1:0] ia, input logic [WB-1:0] ib,
                         input logic iua, input logic iub, input int inject_cyc,
                         output int done_cyc, output int done_count, output int busy_bad,
                         output logic [WA-1:0] q, output logic [WB-1:0] r, output logic dz,
                         output logic [WA-1:0] q_end, output logic [WB-1:0] r_end);
        a = ia; b = ib; unsigned_a = iua; unsigned_b = iub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = WA'($urandom); b = WB'($urandom);
        unsigned_a = 1'($urandom); unsigned_b = 1'($urandom);
        done_cyc = -1; done_count = 0; busy_bad = 0;
        q = '0; r = '0; dz = 1'b0;
        for (int cyc = 1; cyc <= RUN_CYCLES; cyc++) begin
            if (cyc == inject_cyc) begin
                a = WA'($urandom); b = WB'($urandom) | WB'(1); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                if (done_cyc < 0) begin
                    done_cyc = cyc; q = quotient; r = remainder; dz = div_zero;
                end
                done_count++;
            end
            if ((done_cyc < 0 || cyc == done_cyc) ? (busy !== 1'b1) : (busy !== 1'b0))
                busy_bad++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        q_end = quotient; r_end = remainder;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; unsigned_a = 1'b1; unsigned_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_zero, quotient, remainder} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_basic;
        int dc, dn, bb;
        logic [WA-1:0] q, qe; logic [WB-1:0] r, re; logic dz;
        do_op(20'd100, 18'd7, 1'b1, 1'b1, 0, dc, dn, bb, q, r, dz, qe, re);
        total++;
        if (q !== 20'd14 || r !== 18'd2 || dz !== 1'b0) begin
            bad++; $display("FAIL basic_result: q=%0d r=%0d dz=%b, want 14 2 0", q, r, dz);
        end
        total++;
        if (dc !== 22 || dn !== 1) begin
            bad++; $display("FAIL basic_latency: done at %0d count %0d, want 22 once", dc, dn);
        end
        total++;
        if (bb !== 0) begin
            bad++; $display("FAIL basic_busy: %0d bad busy cycles, want 0", bb);
        end
        total++;
        if (qe !== 20'd14 || re !== 18'd2) begin
            bad++; $display("FAIL basic_hold: q=%0d r=%0d later, want 14 2", qe, re);
        end
    endtask

    task automatic test_sign_modes;
        int dc, dn, bb;
        logic [WA-1:0] q, qe, eq; logic [WB-1:0] r, re, er; logic dz;
        do_op(20'hFFF9C, 18'd7, 1'b0, 1'b1, 0, dc, dn, bb, q, r, dz, qe, re);
        eq = SIGNED_EN ? 20'hFFFF2 : 20'h24916;
        er = SIGNED_EN ? 18'h3FFFE : 18'd2;
        total++;
        if (q !== eq || r !== er || dz !== 1'b0 || dc !== 22) begin
            bad++; $display("FAIL neg_dividend: q=%h r=%h dz=%b cyc=%0d, want %h %h 0 22",
                            q, r, dz, dc, eq, er);
        end
        do_op(20'h80000, 18'h3FFFF, 1'b0, 1'b0, 0, dc, dn, bb, q, r, dz, qe, re);
        eq = SIGNED_EN ? 20'h80000 : 20'd2;
        er = SIGNED_EN ? 18'd0 : 18'd2;
        total++;
        if (q !== eq || r !== er || dz !== 1'b0) begin
            bad++; $display("FAIL most_neg_div_m1: q=%h r=%h dz=%b, want %h %h 0", q, r, dz, eq, er);
        end
    endtask

    task automatic test_div_zero;
        int dc, dn, bb;
        logic [WA-1:0] q, qe; logic [WB-1:0] r, re; logic dz;
        do_op(20'h12345, 18'd0, 1'b1, 1'b1, 0, dc, dn, bb, q, r, dz, qe, re);
        total++;
        if (q !== 20'hFFFFF || r !== 18'd0 || dz !== 1'b1) begin
            bad++; $display("FAIL div_zero_result: q=%h r=%h dz=%b, want fffff 0 1", q, r, dz);
        end
        total++;
        if (dc !== 1 || dn !== 1 || bb !== 0) begin
            bad++; $display("FAIL div_zero_timing: done at %0d count %0d busybad %0d, want 1 1 0",
                            dc, dn, bb);
        end
    endtask

    task automatic test_random;
        int dc, dn, bb;
        logic [WA-1:0] q, qe, eq, ra; logic [WB-1:0] r, re, er, rb; logic dz, edz, ua, ub;
        for (int i = 0; i < 40; i++) begin
            ra = WA'($urandom); rb = WB'($urandom);
            ua = 1'($urandom); ub = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = WB'($urandom_range(1, 15));
                2: ra = 20'h80000;
                3: rb = '1;
                default: ;
            endcase
            model(ra, rb, ua, ub, eq, er, edz);
            do_op(ra, rb, ua, ub, 0, dc, dn, bb, q, r, dz, qe, re);
            total++;
            if (q !== eq || r !== er || dz !== edz) begin
                bad++; $display("FAIL rand_result[%0d]: a=%h b=%h ua=%b ub=%b got q=%h r=%h dz=%b want %h %h %b",
                                i, ra, rb, ua, ub, q, r, dz, eq, er, edz);
            end
            total++;
            if (dc !== (edz ? 1 : 22) || dn !== 1 || bb !== 0 || qe !== eq || re !== er) begin
                bad++; $display("FAIL rand_timing[%0d]: done at %0d count %0d busybad %0d hold q=%h r=%h",
                                i, dc, dn, bb, qe, re);
            end
        end
    endtask

    task automatic test_busy_start;
        int dc, dn, bb;
        logic [WA-1:0] q, qe, eq; logic [WB-1:0] r, re, er; logic dz, edz;
        model(20'd999999, 18'd1234, 1'b1, 1'b1, eq, er, edz);
        do_op(20'd999999, 18'd1234, 1'b1, 1'b1, 5, dc, dn, bb, q, r, dz, qe, re);
        total++;
        if (q !== eq || r !== er || dc !== 22 || dn !== 1 || bb !== 0) begin
            bad++; $display("FAIL busy_start: q=%0d r=%0d cyc=%0d count=%0d busybad=%0d, want %0d %0d 22 1 0",
                            q, r, dc, dn, bb, eq, er);
        end
    endtask

    task automatic test_done_start;
        int dc, dn, bb;
        logic [WA-1:0] q, qe, eq; logic [WB-1:0] r, re, er; logic dz, edz;
        model(20'd54321, 18'd100, 1'b1, 1'b1, eq, er, edz);
        do_op(20'd54321, 18'd100, 1'b1, 1'b1, 22, dc, dn, bb, q, r, dz, qe, re);
        total++;
        if (q !== eq || r !== er || dc !== 22 || dn !== 1 || bb !== 0 || qe !== eq) begin
            bad++; $display("FAIL done_start: q=%0d r=%0d cyc=%0d count=%0d busybad=%0d, want %0d %0d 22 1 0",
                            q, r, dc, dn, bb, eq, er);
        end
    endtask

    task automatic test_reset_abort;
        int dc, dn, bb, seen;
        logic [WA-1:0] q, qe, eq; logic [WB-1:0] r, re, er; logic dz, edz;
        a = 20'd500000; b = 18'd3; unsigned_a = 1'b1; unsigned_b = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_zero, quotient, remainder} !== '0) begin
            bad++; $display("FAIL abort_outputs: busy=%b done=%b dz=%b q=%h r=%h, want all 0",
                            busy, done, div_zero, quotient, remainder);
        end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (RUN_CYCLES) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL abort_no_done: %0d cycles with done/busy set, want 0", seen);
        end
        model(20'd1000, 18'd9, 1'b1, 1'b1, eq, er, edz);
        do_op(20'd1000, 18'd9, 1'b1, 1'b1, 0, dc, dn, bb, q, r, dz, qe, re);
        total++;
        if (q !== eq || r !== er || dz !== 1'b0 || dc !== 22 || dn !== 1) begin
            bad++; $display("FAIL after_abort: q=%0d r=%0d dz=%b cyc=%0d, want %0d %0d 0 22",
                            q, r, dz, dc, eq, er);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned_basic();
        test_sign_modes();
        test_div_zero();
        test_random();
        test_busy_start();
        test_done_start();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
